// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared defaults and the clog2 helper for the stream demux.
// Revision    : 1.0
// ============================================================================
package stream_demux_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NCH    = 8;
    localparam int DROP_CNT_W = 8;

    // Bounded loop keeps the function usable as a constant in elaboration.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry valid/ready register slot (load, hold, drain).
// Revision    : 1.0
// ============================================================================
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // The parent only loads when the slot is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux
// Description : 1-to-NCH stream demultiplexer with per-channel slots and a
//               saturating drop counter for out-of-range selects.
//               Optional broadcast enabled by STREAM_DEMUX_BCAST_EN.
// Revision    : 1.0
// ============================================================================
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_bcast,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*WIDTH-1:0]  out_data,
    output logic                  err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int              c_sel_span = 1 << SELW;
    localparam logic [SELW:0]   c_nch      = (SELW + 1)'(NCH);
    localparam logic [DROP_CNT_W-1:0] c_cnt_max = {DROP_CNT_W{1'b1}};

    logic [NCH-1:0]        w_free;
    logic [c_sel_span-1:0] w_free_ext;
    logic [NCH-1:0]        w_load;
    logic                  w_sel_ok;
    logic                  w_sel_ready;
    logic                  w_bcast;
    logic                  w_accept;
    logic                  w_drop;

    logic                  r_err;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign w_free   = ~out_valid | out_ready;
    assign w_sel_ok = ({1'b0, in_sel} < c_nch);

    // Pad the free vector so any select value indexes a defined bit.
    generate
        for (genvar k = 0; k < c_sel_span; k++) begin : g_free_ext
            if (k < NCH) begin : g_real
                assign w_free_ext[k] = w_free[k];
            end else begin : g_pad
                assign w_free_ext[k] = 1'b1;
            end
        end
    endgenerate

    assign w_sel_ready = w_sel_ok ? w_free_ext[in_sel] : 1'b1;

`ifdef STREAM_DEMUX_BCAST_EN
    assign w_bcast  = in_bcast;
    assign in_ready = w_bcast ? (&w_free) : w_sel_ready;
`else
    logic w_unused_bcast;
    assign w_unused_bcast = in_bcast;
    assign w_bcast        = 1'b0;
    assign in_ready       = w_sel_ready;
`endif

    assign w_accept = in_valid & in_ready;
    assign w_drop   = w_accept & ~w_bcast & ~w_sel_ok;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_slot
            assign w_load[k] = w_accept &
                               (w_bcast | (w_sel_ok & (in_sel == SELW'(k))));

            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[k]),
                .i_data  (in_data),
                .i_ready (out_ready[k]),
                .o_valid (out_valid[k]),
                .o_data  (out_data[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err <= w_drop;
            if (w_drop && (r_drop_cnt != c_cnt_max)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign err      = r_err;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux
// Description : Self-checking bench for stream_demux (NCH=8 and NCH=6 units).
// Revision    : 1.0
// ============================================================================
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid8, in_ready8, in_bcast8;
    logic [7:0]  in_data8;
    logic [2:0]  in_sel8;
    logic [7:0]  out_valid8, out_ready8;
    logic [63:0] out_data8;
    logic        err8;
    logic [7:0]  drop_cnt8;

    logic        in_valid6, in_ready6, in_bcast6;
    logic [7:0]  in_data6;
    logic [2:0]  in_sel6;
    logic [5:0]  out_valid6, out_ready6;
    logic [47:0] out_data6;
    logic        err6;
    logic [7:0]  drop_cnt6;

    int checks = 0;
    int failures = 0;

    logic [7:0] sbq [8][$];

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(8), .NCH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_sel(in_sel8), .in_bcast(in_bcast8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .err(err8), .drop_cnt(drop_cnt8)
    );

    stream_demux #(.WIDTH(8), .NCH(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_data(in_data6), .in_sel(in_sel6), .in_bcast(in_bcast6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .err(err6), .drop_cnt(drop_cnt6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid8 = 1'b0; in_bcast8 = 1'b0; in_sel8 = 3'd0; in_data8 = 8'h00;
        out_ready8 = 8'hFF;
        in_valid6 = 1'b0; in_bcast6 = 1'b0; in_sel6 = 3'd0; in_data6 = 8'h00;
        out_ready6 = 6'h3F;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        in_valid8 = 1'b1; in_sel8 = 3'd1; in_data8 = 8'hEE;
        tick(); tick();
        checks++; if (out_valid8 !== 8'h00) begin failures++; $display("FAIL reset_valid8 got=%h exp=00", out_valid8); end
        checks++; if (out_data8 !== 64'h0) begin failures++; $display("FAIL reset_data8 got=%h exp=0", out_data8); end
        checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL reset_err8 got=%b exp=0", err8); end
        checks++; if (drop_cnt8 !== 8'h00) begin failures++; $display("FAIL reset_cnt8 got=%h exp=00", drop_cnt8); end
        checks++; if (out_valid6 !== 6'h00) begin failures++; $display("FAIL reset_valid6 got=%h exp=00", out_valid6); end
        checks++; if (drop_cnt6 !== 8'h00) begin failures++; $display("FAIL reset_cnt6 got=%h exp=00", drop_cnt6); end
        rst_n = 1'b1;
        in_valid8 = 1'b0;
        tick();
        checks++; if (out_valid8 !== 8'h00) begin failures++; $display("FAIL reset_noaccept got=%h exp=00", out_valid8); end
    endtask

    task automatic test_route();
        idle_inputs();
        for (int s = 0; s < 8; s++) begin
            in_valid8 = 1'b1; in_sel8 = 3'(s); in_data8 = 8'hA0 + 8'(s);
            #1;
            checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL route_ready s=%0d got=%b exp=1", s, in_ready8); end
            tick();
            checks++; if (out_valid8 !== (8'h01 << s)) begin failures++; $display("FAIL route_valid s=%0d got=%h exp=%h", s, out_valid8, 8'h01 << s); end
            checks++; if (out_data8[s*8 +: 8] !== 8'hA0 + 8'(s)) begin failures++; $display("FAIL route_data s=%0d got=%h exp=%h", s, out_data8[s*8 +: 8], 8'hA0 + 8'(s)); end
        end
        in_valid8 = 1'b0;
        tick();
        checks++; if (out_valid8 !== 8'h00) begin failures++; $display("FAIL route_idle got=%h exp=00", out_valid8); end
    endtask

    task automatic test_hold();
        idle_inputs();
        out_ready8 = 8'hF7;
        in_valid8 = 1'b1; in_sel8 = 3'd3; in_data8 = 8'h11;
        #1;
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL hold_first_ready got=%b exp=1", in_ready8); end
        tick();
        in_data8 = 8'h22;
        #1;
        checks++; if (in_ready8 !== 1'b0) begin failures++; $display("FAIL hold_second_ready got=%b exp=0", in_ready8); end
        out_ready8 = 8'h00;
        #1;
        checks++; if (in_ready8 !== 1'b0) begin failures++; $display("FAIL hold_other_ready got=%b exp=0", in_ready8); end
        out_ready8 = 8'hF7;
        tick();
        checks++; if (out_valid8 !== 8'h08) begin failures++; $display("FAIL hold_valid got=%h exp=08", out_valid8); end
        checks++; if (out_data8[24 +: 8] !== 8'h11) begin failures++; $display("FAIL hold_data got=%h exp=11", out_data8[24 +: 8]); end
        out_ready8 = 8'hFF;
        #1;
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", in_ready8); end
        tick();
        checks++; if (out_valid8 !== 8'h08) begin failures++; $display("FAIL hold_second_valid got=%h exp=08", out_valid8); end
        checks++; if (out_data8[24 +: 8] !== 8'h22) begin failures++; $display("FAIL hold_second_data got=%h exp=22", out_data8[24 +: 8]); end
        in_valid8 = 1'b0;
        tick();
        checks++; if (out_valid8 !== 8'h00) begin failures++; $display("FAIL hold_drained got=%h exp=00", out_valid8); end
    endtask

    task automatic test_drop();
        idle_inputs();
        in_valid6 = 1'b1; in_sel6 = 3'd7; in_data6 = 8'h99;
        #1;
        checks++; if (in_ready6 !== 1'b1) begin failures++; $display("FAIL drop_ready got=%b exp=1", in_ready6); end
        checks++; if (err6 !== 1'b0) begin failures++; $display("FAIL drop_err_early got=%b exp=0", err6); end
        tick();
        in_valid6 = 1'b0;
        checks++; if (err6 !== 1'b1) begin failures++; $display("FAIL drop_err got=%b exp=1", err6); end
        checks++; if (drop_cnt6 !== 8'd1) begin failures++; $display("FAIL drop_cnt1 got=%0d exp=1", drop_cnt6); end
        checks++; if (out_valid6 !== 6'h00) begin failures++; $display("FAIL drop_valid got=%h exp=00", out_valid6); end
        tick();
        checks++; if (err6 !== 1'b0) begin failures++; $display("FAIL drop_err_pulse got=%b exp=0", err6); end
        in_valid6 = 1'b1; in_sel6 = 3'd6;
        for (int i = 0; i < 254; i++) tick();
        checks++; if (drop_cnt6 !== 8'd255) begin failures++; $display("FAIL drop_cnt255 got=%0d exp=255", drop_cnt6); end
        checks++; if (err6 !== 1'b1) begin failures++; $display("FAIL drop_err_run got=%b exp=1", err6); end
        for (int i = 0; i < 45; i++) tick();
        checks++; if (drop_cnt6 !== 8'd255) begin failures++; $display("FAIL drop_cnt_sat got=%0d exp=255", drop_cnt6); end
        in_sel6 = 3'd5; in_data6 = 8'h3C;
        tick();
        in_valid6 = 1'b0;
        checks++; if (out_valid6 !== 6'h20) begin failures++; $display("FAIL drop_inrange_valid got=%h exp=20", out_valid6); end
        checks++; if (out_data6[40 +: 8] !== 8'h3C) begin failures++; $display("FAIL drop_inrange_data got=%h exp=3c", out_data6[40 +: 8]); end
        checks++; if (err6 !== 1'b0) begin failures++; $display("FAIL drop_inrange_err got=%b exp=0", err6); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        out_ready8 = 8'h00;
        in_valid8 = 1'b1; in_sel8 = 3'd2; in_data8 = 8'h42;
        tick();
        checks++; if (out_valid8 !== 8'h04) begin failures++; $display("FAIL rmid_fill got=%h exp=04", out_valid8); end
        rst_n = 1'b0;
        in_sel8 = 3'd5; in_data8 = 8'h55;
        in_valid6 = 1'b1; in_sel6 = 3'd7;
        tick();
        checks++; if (out_valid8 !== 8'h00) begin failures++; $display("FAIL rmid_valid got=%h exp=00", out_valid8); end
        checks++; if (out_data8 !== 64'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", out_data8); end
        checks++; if (drop_cnt6 !== 8'd0) begin failures++; $display("FAIL rmid_cnt6 got=%0d exp=0", drop_cnt6); end
        checks++; if (err6 !== 1'b0) begin failures++; $display("FAIL rmid_err6 got=%b exp=0", err6); end
        rst_n = 1'b1;
        in_valid8 = 1'b0; in_valid6 = 1'b0; out_ready8 = 8'hFF;
        tick();
        checks++; if (out_valid8 !== 8'h00) begin failures++; $display("FAIL rmid_noaccept got=%h exp=00", out_valid8); end
        checks++; if (err6 !== 1'b0) begin failures++; $display("FAIL rmid_noerr got=%b exp=0", err6); end
    endtask

`ifdef STREAM_DEMUX_BCAST_EN
    task automatic test_bcast();
        idle_inputs();
        in_valid8 = 1'b1; in_bcast8 = 1'b1; in_sel8 = 3'd3; in_data8 = 8'h5C;
        in_valid6 = 1'b1; in_bcast6 = 1'b1; in_sel6 = 3'd7; in_data6 = 8'h5C;
        #1;
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL bcast_ready got=%b exp=1", in_ready8); end
        tick();
        in_valid6 = 1'b0; in_bcast6 = 1'b0;
        checks++; if (out_valid8 !== 8'hFF) begin failures++; $display("FAIL bcast_valid got=%h exp=ff", out_valid8); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (out_data8[k*8 +: 8] !== 8'h5C) begin failures++; $display("FAIL bcast_data k=%0d got=%h exp=5c", k, out_data8[k*8 +: 8]); end
        end
        checks++; if (out_valid6 !== 6'h3F) begin failures++; $display("FAIL bcast_valid6 got=%h exp=3f", out_valid6); end
        checks++; if (err6 !== 1'b0) begin failures++; $display("FAIL bcast_err6 got=%b exp=0", err6); end
        out_ready8 = 8'hEF; in_data8 = 8'h77;
        #1;
        checks++; if (in_ready8 !== 1'b0) begin failures++; $display("FAIL bcast_block got=%b exp=0", in_ready8); end
        tick();
        checks++; if (out_valid8 !== 8'h10) begin failures++; $display("FAIL bcast_held got=%h exp=10", out_valid8); end
        checks++; if (out_data8[32 +: 8] !== 8'h5C) begin failures++; $display("FAIL bcast_held_data got=%h exp=5c", out_data8[32 +: 8]); end
        checks++; if (in_ready8 !== 1'b0) begin failures++; $display("FAIL bcast_block2 got=%b exp=0", in_ready8); end
        out_ready8 = 8'hFF;
        #1;
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL bcast_unblock got=%b exp=1", in_ready8); end
        tick();
        in_valid8 = 1'b0; in_bcast8 = 1'b0;
        checks++; if (out_valid8 !== 8'hFF) begin failures++; $display("FAIL bcast_valid2 got=%h exp=ff", out_valid8); end
        checks++; if (out_data8 !== {8{8'h77}}) begin failures++; $display("FAIL bcast_data2 got=%h exp=77..", out_data8); end
        tick();
    endtask
`else
    task automatic test_bcast_ignored();
        idle_inputs();
        in_valid8 = 1'b1; in_bcast8 = 1'b1; in_sel8 = 3'd3; in_data8 = 8'h5C;
        in_valid6 = 1'b1; in_bcast6 = 1'b1; in_sel6 = 3'd7; in_data6 = 8'h5C;
        tick();
        in_valid8 = 1'b0; in_valid6 = 1'b0;
        checks++; if (out_valid8 !== 8'h08) begin failures++; $display("FAIL nobcast_valid got=%h exp=08", out_valid8); end
        checks++; if (out_data8[24 +: 8] !== 8'h5C) begin failures++; $display("FAIL nobcast_data got=%h exp=5c", out_data8[24 +: 8]); end
        checks++; if (err6 !== 1'b1) begin failures++; $display("FAIL nobcast_err6 got=%b exp=1", err6); end
        tick();
    endtask
`endif

    task automatic test_random(input int n);
        logic [7:0] exp_v;
        logic [7:0] free;
        logic       exp_rdy;
        logic       mbcast;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) sbq[k].delete();
        for (int c = 0; c < n; c++) begin
            in_valid8  = ($urandom_range(0, 3) != 0);
            in_sel8    = 3'($urandom_range(0, 7));
            in_data8   = 8'($urandom_range(0, 255));
            in_bcast8  = ($urandom_range(0, 7) == 0);
            out_ready8 = 8'($urandom_range(0, 255));
`ifdef STREAM_DEMUX_BCAST_EN
            mbcast = in_bcast8;
`else
            mbcast = 1'b0;
`endif
            #1;
            for (int k = 0; k < 8; k++) begin
                exp_v[k] = (sbq[k].size() != 0);
                free[k]  = !exp_v[k] || out_ready8[k];
            end
            exp_rdy = mbcast ? (&free) : free[in_sel8];
            checks++; if (out_valid8 !== exp_v) begin failures++; $display("FAIL rand_valid c=%0d got=%h exp=%h", c, out_valid8, exp_v); end
            checks++; if (in_ready8 !== exp_rdy) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready8, exp_rdy); end
            for (int k = 0; k < 8; k++) begin
                if (exp_v[k] && out_ready8[k]) begin
                    checks++;
                    if (out_data8[k*8 +: 8] !== sbq[k][0]) begin
                        failures++;
                        $display("FAIL rand_data c=%0d k=%0d got=%h exp=%h", c, k, out_data8[k*8 +: 8], sbq[k][0]);
                    end
                    void'(sbq[k].pop_front());
                end
            end
            if (in_valid8 && exp_rdy) begin
                if (mbcast) begin
                    for (int k = 0; k < 8; k++) sbq[k].push_back(in_data8);
                end else begin
                    sbq[in_sel8].push_back(in_data8);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_route();
        test_hold();
        test_drop();
        test_reset_mid();
`ifdef STREAM_DEMUX_BCAST_EN
        test_bcast();
`else
        test_bcast_ignored();
`endif
        test_random(2000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 8: data bits per beat.
REQ-002 Parameter NCH, default 8: number of output channels, legal range 2..16.
REQ-003 Derived constant SELW = clog2(NCH): select width.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: synchronous, active-low reset.
REQ-006 in_valid  input  1: input beat offered.
REQ-007 in_ready  output  1: input beat accepted when in_valid && in_ready.
REQ-008 in_data  input  WIDTH: input payload.
REQ-009 in_sel  input  SELW: destination channel.
REQ-010 in_bcast  input  1: broadcast request; used only when STREAM_DEMUX_BCAST_EN is defined.
REQ-011 out_valid  output  NCH: per-channel beat present.
REQ-012 out_ready  input  NCH: per-channel consumer ready.
REQ-013 out_data  output  NCH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 err  output  1: one-cycle pulse for a dropped beat.
REQ-015 drop_cnt  output  8: saturating count of dropped beats.

Function
REQ-016 Each channel has a one-entry output slot; a beat is transferred on a channel when out_valid[k] && out_ready[k].
REQ-017 Latency is 1 cycle: a beat accepted in cycle N appears as out_valid[in_sel] = 1 in cycle N+1.
REQ-018 For in_sel < NCH, in_ready = !out_valid[in_sel] || out_ready[in_sel], combinational; a slot that drains and refills in the same cycle sustains full throughput.
REQ-019 For in_sel >= NCH, in_ready = 1, the beat is discarded, err pulses in the following cycle, and drop_cnt increments.
REQ-020 drop_cnt saturates at 255 and holds at that value.
REQ-021 A slot holds out_data and out_valid stable while out_valid && !out_ready.
REQ-022 A slot's out_data is unchanged whenever it is not loaded.
REQ-023 in_ready has no dependency on out_ready of non-selected channels.
REQ-024 Simultaneous accept on channel k and drain on channel j != k are independent.
REQ-025 in_ready may be high while in_valid is low.

Reset
REQ-026 While rst_n = 0 at a clock edge: out_valid = 0, out_data = 0, err = 0, drop_cnt = 0.
REQ-027 Beats held in slots when reset is asserted mid-operation are lost.
REQ-028 in_valid is ignored in any cycle in which rst_n = 0.

Configuration
REQ-029 With STREAM_DEMUX_BCAST_EN defined, in_valid && in_bcast loads in_data into every slot, and in_sel is ignored for that beat.
REQ-030 With STREAM_DEMUX_BCAST_EN defined, a broadcast beat is accepted only when every slot is empty or draining in that cycle (in_ready = AND over k of (!out_valid[k] || out_ready[k])).
REQ-031 With STREAM_DEMUX_BCAST_EN defined, a broadcast beat never raises err.
REQ-032 Without STREAM_DEMUX_BCAST_EN, in_bcast is ignored and treated as 0, and no broadcast logic is synthesized.

Structure
REQ-033 Package stream_demux_pkg holds the WIDTH/NCH defaults, DROP_CNT_W = 8, and the clog2 helper function.
REQ-034 Sub-module demux_slot implements one WIDTH-bit valid/ready register slot (load, hold, drain); it is instantiated NCH times with a generate loop.
REQ-035 Select decode, drop logic and the counter reside in stream_demux.

Verification
REQ-036 Reset, then route WIDTH=8, NCH=8, in_sel = 0..7 with in_data = 8'hA0+sel and all out_ready = 1 -> channel k shows out_valid[k] = 1 with data A0+k exactly 1 cycle after its accept, and no other channel asserts out_valid.
REQ-037 Hold out_ready[3] = 0 and send two beats with sel = 3 -> the first beat is held; in_ready = 0 for the second; raising out_ready[3] accepts the second beat in the same cycle and it appears on the next cycle.
REQ-038 NCH = 6, send in_sel = 7 -> in_ready = 1, err pulses exactly one cycle later, drop_cnt = 1, and no out_valid is asserted; 300 drops -> drop_cnt = 255.
REQ-039 Fill channel 2, then assert rst_n = 0 for 1 cycle with in_valid = 1 -> all outputs are 0 after the edge and no beat is accepted.
REQ-040 With the macro defined, in_bcast = 1, data = 8'h5C, and all out_ready = 1 -> all 8 slots hold 5C the next cycle; with out_ready[4] = 0 and slot 4 full -> in_ready = 0 until channel 4 drains.
REQ-041 Random back-to-back traffic against a scoreboard, in both macro builds -> per-channel order is preserved, with no loss and no duplication.
